// File: rtl/csr_trap_pkg.sv
// csr_trap_pkg: CSR addresses, trap cause codes and sequencer state encoding.
package csr_trap_pkg;
   localparam logic [11:0] CSR_MEPC   = 12'h341;
   localparam logic [11:0] CSR_MCAUSE = 12'h342;
   localparam logic [11:0] CSR_MTVAL  = 12'h343;
   localparam logic [3:0] CAUSE_INST_MISALIGNED  = 4'd0;
   localparam logic [3:0] CAUSE_ILLEGAL          = 4'd2;
   localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
   localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_W_MEPC,
      ST_W_MCAUSE,
      ST_W_MTVAL,
      ST_T_REDIRECT,
      ST_R_MEPC,
      ST_RET_WAIT,
      ST_RET_REDIRECT
   } state_t;
endpackage

// File: rtl/trap_cause_encoder.sv
// trap_cause_encoder: trap request priority and mcause selection.
module trap_cause_encoder
   import csr_trap_pkg::*;
(
   input  logic       i_illinst,
   input  logic       i_misaligned,
   input  logic [1:0] i_kind,
   output logic       o_trap,
   output logic [3:0] o_cause
);
   assign o_trap  = i_illinst | i_misaligned;
   assign o_cause = i_illinst      ? CAUSE_ILLEGAL :
                    i_kind == 2'd0 ? CAUSE_INST_MISALIGNED :
                    i_kind == 2'd1 ? CAUSE_LOAD_MISALIGNED : CAUSE_STORE_MISALIGNED;
endmodule

// File: rtl/csr_trap_sequencer.sv
// csr_trap_sequencer: writes mepc/mcause on a trap or reads mepc on mret, then redirects fetch.
// Build option TRAP_MTVAL_EN adds an mtval write to the trap sequence.
module csr_trap_sequencer
   import csr_trap_pkg::*;
#(
   parameter int                XLEN       = 32,
   parameter logic [XLEN-1:0]   MTVEC_BASE = 32'h0000_0010
)(
   input  logic            clk,
   input  logic            reset,
   input  logic            initiate_illinst,
   input  logic            initiate_misaligned,
   input  logic [1:0]      misaligned_kind,
   input  logic            mret_req,
   input  logic [XLEN-1:0] exc_pc,
   input  logic [XLEN-1:0] exc_tval,
   output logic            csr_read,
   output logic            csr_write,
   output logic [11:0]     csr_addr,
   output logic [XLEN-1:0] csr_wdata,
   input  logic [XLEN-1:0] csr_rdata,
   output logic            stall,
   output logic            flush,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            double_fault
);
   state_t      r_state;
   logic [3:0]  r_cause;
   logic        w_trap;
   logic [3:0]  w_cause;
`ifdef TRAP_MTVAL_EN
   logic [XLEN-1:0] r_tval;
`else
   logic w_unused_tval;
   assign w_unused_tval = ^exc_tval;
`endif

   trap_cause_encoder u_enc (
      .i_illinst    (initiate_illinst),
      .i_misaligned (initiate_misaligned),
      .i_kind       (misaligned_kind),
      .o_trap       (w_trap),
      .o_cause      (w_cause)
   );

   assign stall = (r_state != ST_IDLE) | w_trap | mret_req;

   // CSR/redirect outputs are registered: each arm sets what the next state drives.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= ST_IDLE;
         r_cause        <= '0;
`ifdef TRAP_MTVAL_EN
         r_tval         <= '0;
`endif
         csr_read       <= 1'b0;
         csr_write      <= 1'b0;
         csr_addr       <= '0;
         csr_wdata      <= '0;
         flush          <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         double_fault   <= 1'b0;
      end else begin
         csr_read       <= 1'b0;
         csr_write      <= 1'b0;
         csr_addr       <= '0;
         csr_wdata      <= '0;
         flush          <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         if (r_state != ST_IDLE && w_trap) double_fault <= 1'b1;
         case (r_state)
            ST_IDLE: begin
               if (w_trap) begin
                  r_cause   <= w_cause;
`ifdef TRAP_MTVAL_EN
                  r_tval    <= exc_tval;
`endif
                  r_state   <= ST_W_MEPC;
                  csr_write <= 1'b1;
                  csr_addr  <= CSR_MEPC;
                  csr_wdata <= {exc_pc[XLEN-1:2], 2'b00};
               end else if (mret_req) begin
                  r_state  <= ST_R_MEPC;
                  csr_read <= 1'b1;
                  csr_addr <= CSR_MEPC;
               end
            end
            ST_W_MEPC: begin
               r_state   <= ST_W_MCAUSE;
               csr_write <= 1'b1;
               csr_addr  <= CSR_MCAUSE;
               csr_wdata <= {{(XLEN-4){1'b0}}, r_cause};
            end
`ifdef TRAP_MTVAL_EN
            ST_W_MCAUSE: begin
               r_state   <= ST_W_MTVAL;
               csr_write <= 1'b1;
               csr_addr  <= CSR_MTVAL;
               csr_wdata <= r_tval;
            end
            ST_W_MTVAL: begin
`else
            ST_W_MCAUSE: begin
`endif
               r_state        <= ST_T_REDIRECT;
               redirect_valid <= 1'b1;
               redirect_pc    <= MTVEC_BASE;
               flush          <= 1'b1;
            end
            ST_R_MEPC: r_state <= ST_RET_WAIT;
            ST_RET_WAIT: begin
               r_state        <= ST_RET_REDIRECT;
               redirect_valid <= 1'b1;
               redirect_pc    <= {csr_rdata[XLEN-1:2], 2'b00};
               flush          <= 1'b1;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_csr_trap_sequencer.sv
// tb_csr_trap_sequencer: directed checks of trap and mret sequences, double fault and async reset.
module tb_csr_trap_sequencer;
   logic        clk = 1'b0;
   logic        reset;
   logic        initiate_illinst, initiate_misaligned, mret_req;
   logic [1:0]  misaligned_kind;
   logic [31:0] exc_pc, exc_tval, csr_wdata, csr_rdata, redirect_pc;
   logic        csr_read, csr_write, stall, flush, redirect_valid, double_fault;
   logic [11:0] csr_addr;
   logic [31:0] mepc_val;
   logic        df_exp;
   int          errs = 0;
   int          checks = 0;

   csr_trap_sequencer dut (
      .clk(clk), .reset(reset),
      .initiate_illinst(initiate_illinst), .initiate_misaligned(initiate_misaligned),
      .misaligned_kind(misaligned_kind), .mret_req(mret_req),
      .exc_pc(exc_pc), .exc_tval(exc_tval),
      .csr_read(csr_read), .csr_write(csr_write), .csr_addr(csr_addr),
      .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
      .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .double_fault(double_fault)
   );

   always #5 clk = ~clk;

   // CSR file model: registered read data, poisoned when no read was issued.
   always @(posedge clk) csr_rdata <= csr_read ? mepc_val : 32'hBAD0_0000;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic bus(input string t, input logic rd, input logic wr, input logic [11:0] a,
                      input logic [31:0] wd, input logic rv, input logic [31:0] rp,
                      input logic fl, input logic st);
      chk({t, "_rd"}, 32'(csr_read), 32'(rd));
      chk({t, "_wr"}, 32'(csr_write), 32'(wr));
      chk({t, "_addr"}, 32'(csr_addr), 32'(a));
      chk({t, "_wdata"}, csr_wdata, wd);
      chk({t, "_rv"}, 32'(redirect_valid), 32'(rv));
      chk({t, "_rpc"}, redirect_pc, rp);
      chk({t, "_flush"}, 32'(flush), 32'(fl));
      chk({t, "_stall"}, 32'(stall), 32'(st));
      chk({t, "_df"}, 32'(double_fault), 32'(df_exp));
   endtask

   task automatic run_trap(input string t, input logic il, input logic mi, input logic [1:0] k,
                           input logic mr, input logic [31:0] pc, input logic [31:0] tv,
                           input logic [3:0] c, input logic inj);
      @(negedge clk);
      initiate_illinst = il; initiate_misaligned = mi; misaligned_kind = k; mret_req = mr;
      exc_pc = pc; exc_tval = tv;
      #1 bus({t, "_trig"}, 0, 0, 12'h0, 0, 0, 0, 0, 1);
      @(negedge clk);
      initiate_illinst = 0; initiate_misaligned = 0; misaligned_kind = 0; mret_req = 1;
      #1 bus({t, "_mepc"}, 0, 1, 12'h341, pc & 32'hFFFF_FFFC, 0, 0, 0, 1);
      @(negedge clk);
      mret_req = 0; initiate_illinst = inj;
      #1 bus({t, "_mcause"}, 0, 1, 12'h342, {28'd0, c}, 0, 0, 0, 1);
      @(negedge clk);
      initiate_illinst = 0;
      df_exp = df_exp | inj;
`ifdef TRAP_MTVAL_EN
      #1 bus({t, "_mtval"}, 0, 1, 12'h343, tv, 0, 0, 0, 1);
      @(negedge clk);
`endif
      #1 bus({t, "_redir"}, 0, 0, 12'h0, 0, 1, 32'h10, 1, 1);
      @(negedge clk);
      #1 bus({t, "_idle"}, 0, 0, 12'h0, 0, 0, 0, 0, 0);
   endtask

   task automatic run_mret(input string t, input logic [31:0] v);
      mepc_val = v;
      @(negedge clk);
      mret_req = 1;
      #1 bus({t, "_trig"}, 0, 0, 12'h0, 0, 0, 0, 0, 1);
      @(negedge clk);
      mret_req = 0;
      #1 bus({t, "_read"}, 1, 0, 12'h341, 0, 0, 0, 0, 1);
      @(negedge clk);
      #1 bus({t, "_wait"}, 0, 0, 12'h0, 0, 0, 0, 0, 1);
      @(negedge clk);
      #1 bus({t, "_redir"}, 0, 0, 12'h0, 0, 1, v & 32'hFFFF_FFFC, 1, 1);
      @(negedge clk);
      #1 bus({t, "_idle"}, 0, 0, 12'h0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      reset = 1; initiate_illinst = 0; initiate_misaligned = 0; misaligned_kind = 0;
      mret_req = 0; exc_pc = 0; exc_tval = 0; mepc_val = 0; df_exp = 0;
      repeat (2) @(negedge clk);
      #1 bus("reset", 0, 0, 12'h0, 0, 0, 0, 0, 0);
      @(negedge clk);
      reset = 0;
      run_trap("ill", 1, 0, 2'd0, 0, 32'h0000_0104, 32'h0000_DEAD, 4'd2, 0);
      run_trap("ld", 0, 1, 2'd1, 0, 32'h0000_0203, 32'h0000_2003, 4'd4, 0);
      run_trap("inst", 0, 1, 2'd0, 0, 32'h0000_1002, 32'h0000_1002, 4'd0, 0);
      run_trap("st", 0, 1, 2'd2, 0, 32'h8000_0000, 32'h0000_3001, 4'd6, 0);
      run_trap("k3", 0, 1, 2'd3, 0, 32'h0000_0040, 32'h0000_4005, 4'd6, 0);
      run_mret("mret", 32'h0000_0207);
      run_mret("mret2", 32'hFFFF_FFFF);
      run_trap("all", 1, 1, 2'd1, 1, 32'h0000_0300, 32'h0000_5000, 4'd2, 0);
      run_trap("dfault", 1, 0, 2'd0, 0, 32'h0000_0400, 32'h0000_6000, 4'd2, 1);
      run_mret("mret_df", 32'h0000_0124);
      // Async reset in the middle of the mepc write.
      @(negedge clk);
      initiate_illinst = 1; exc_pc = 32'h0000_0500;
      @(negedge clk);
      initiate_illinst = 0;
      #1 bus("pre_rst", 0, 1, 12'h341, 32'h0000_0500, 0, 0, 0, 1);
      #2 reset = 1;
      df_exp = 0;
      #1 bus("async_rst", 0, 0, 12'h0, 0, 0, 0, 0, 0);
      @(negedge clk);
      reset = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1 bus("post_rst", 0, 0, 12'h0, 0, 0, 0, 0, 0);
      end
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/csr_trap_sequencer.md
Name: csr_trap_sequencer

Overview:
- Initiator side of the CSR file's control/data interface. Consumes initiate_illinst / initiate_misaligned / mret requests and drives the CSR file's single access port through a multi-cycle sequence.
- On a trap: writes mepc, mcause and mtval, then redirects fetch to the trap vector. On mret: reads mepc and redirects fetch to it.
- Sits between the exception handling unit and fetch; stalls the pipeline while the sequence runs.

Parameters:
- MTVEC_BASE, 32'h0000_0010, direct-mode trap vector; bits [1:0] must be 0.
- XLEN, 32, data width; only 32 is supported.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- initiate_illinst  in  1  illegal-instruction trap request (level, sampled in IDLE).
- initiate_misaligned  in  1  misaligned trap request.
- misaligned_kind  in  2  0 = instruction (cause 0), 1 = load (cause 4), 2 = store (cause 6), 3 = treated as store.
- mret_req  in  1  mret committing.
- exc_pc  in  32  pc of the faulting instruction.
- exc_tval  in  32  faulting address or instruction word.
- csr_read  out  1  CSR read strobe.
- csr_write  out  1  CSR write strobe.
- csr_addr  out  12  CSR address.
- csr_wdata  out  32  CSR write data.
- csr_rdata  in  32  registered CSR read data, valid 1 cycle after csr_read.
- stall  out  1  freeze the pipeline.
- flush  out  1  squash FD/XB contents.
- redirect_valid  out  1  one-cycle PC load.
- redirect_pc  out  32  new PC.
- double_fault  out  1  sticky: a trap request arrived while the sequencer was busy.

Behaviour:
- Reset values: all outputs 0, state IDLE, latched pc/tval/cause 0. Reset mid-sequence aborts immediately and issues no further CSR strobes.
- Trigger priority in IDLE: illinst > misaligned > mret_req.
- stall is combinational: (state != IDLE) | (IDLE & any trigger).
- Trap path, latency 4 cycles after the trigger edge (5 with TRAP_MTVAL_EN):
  - IDLE: on trigger, latch exc_pc, exc_tval and cause. Cause is 2 for illegal instruction, else from misaligned_kind.
  - W_MEPC: csr_write = 1, addr 12'h341, wdata = pc & ~3.
  - W_MCAUSE: csr_write = 1, addr 12'h342, wdata = {1'b0, 27'b0, cause[3:0]}.
  - W_MTVAL: only with TRAP_MTVAL_EN; csr_write = 1, addr 12'h343, wdata = tval.
  - T_REDIRECT: redirect_valid = 1, redirect_pc = MTVEC_BASE, flush = 1; return to IDLE.
- Mret path:
  - R_MEPC: csr_read = 1, addr 12'h341.
  - RET_WAIT: capture csr_rdata.
  - RET_REDIRECT: redirect_valid = 1, redirect_pc = captured & ~3, flush = 1; return to IDLE.
- Only one of csr_read / csr_write is asserted in any cycle. When idle, csr_addr and csr_wdata are 0.
- Trap requests while not IDLE are ignored and set double_fault; it clears only on reset.
- mret_req while busy is ignored without any flag.
- A trigger in the redirect cycle is not accepted. It may be re-sampled in the following IDLE cycle if the source still holds it.
- Simultaneous illinst + misaligned: a single trap with cause 2.

Optional Feature:
- TRAP_MTVAL_EN defined: W_MTVAL state present; trap sequence is 5 cycles (trigger + 4 states).
- TRAP_MTVAL_EN undefined: W_MCAUSE goes straight to T_REDIRECT; mtval is never written; exc_tval is unused.

Decomposition:
- Package csr_trap_pkg holds:
  - CSR address constants (MEPC 12'h341, MCAUSE 12'h342, MTVAL 12'h343).
  - Cause codes (INST_MISALIGNED 0, ILLEGAL 2, LOAD_MISALIGNED 4, STORE_MISALIGNED 6).
  - The state encoding.
- Sub-module trap_cause_encoder: combinational priority and cause selection from the request inputs.

Test Plan:
- initiate_illinst = 1, exc_pc = 32'h0000_0104 in IDLE -> one write each, in order: 341 ← 0x104, 342 ← 2, 343 ← tval (MTVAL_EN). Then redirect_pc = 0x10, flush = 1, stall high for all 5 cycles.
- initiate_misaligned, kind = 1, exc_tval = 32'h2003 -> mcause write = 4, mtval write = 0x2003.
- mret_req with CSR model returning 0x0000_0207 -> csr_read at 341; redirect_pc = 0x204 two cycles later.
- illinst + misaligned + mret_req in the same cycle -> single trap with cause 2; no mret read.
- illinst pulsed during W_MCAUSE -> sequence unchanged; double_fault = 1 until reset.
- reset asserted during W_MEPC -> all outputs 0 asynchronously; no further csr_write after release.
